caravel_io_boot: RTL and testbench
==================================

Name: caravel_io_boot

Overview:
- Minimal boot sequencer for the user-project I/O ring.
- After reset it reads a small boot image from an external SPI NOR flash (READ 0x03) and plays it out on mprj_io[7:0] as output patterns.
- Sits between the padframe and the flash pins. It replaces the full management core for I/O bring-up testing.
- Pin mprj_io[3] is reserved as an input (housekeeping CSB) and is never driven.

Parameters:
- BOOT_ADDR, 24'h000000: flash byte address of the boot image.
- STARTUP_CYCLES, 16: clock cycles to wait after reset release before the first flash access.
- SCK_HALF, 1: flash_clk half-period in clock cycles (must be >=1).
- HOLD_CYCLES, 1000: clock cycles each data pattern is held before the next is applied.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- resetb  in  1  asynchronous, active-low reset.
- flash_csb  out  1  flash chip select, active low.
- flash_clk  out  1  SPI clock, mode 0.
- flash_io0  out  1  MOSI.
- flash_io1  in  1  MISO.
- mprj_io_in  in  8  pad input values for io[7:0].
- mprj_io_out  out  8  pad output values.
- mprj_io_oeb  out  8  per-pin output enable, active low (1 = input).
- boot_done  out  1  high once the last pattern is applied; sticky until reset.

Behaviour:
- Reset values (asserted asynchronously while resetb=0):
  - flash_csb=1, flash_clk=0, flash_io0=0.
  - mprj_io_out=8'h00, mprj_io_oeb=8'hFF, boot_done=0.
  - All counters and the FSM are cleared.
- Reset mid-transaction aborts immediately: csb goes high asynchronously. On release the sequence restarts from WAIT.
- Boot image at BOOT_ADDR, in byte order:
  - N: pattern count, 0..255.
  - M: output mask (1 = drive the pin).
  - D0..D(N-1): data patterns.
- FSM states: WAIT -> CMD -> ADDR -> HDR -> MASK -> DATA -> HOLD -> ... -> DONE.
- WAIT: count STARTUP_CYCLES clocks after reset release, then drive csb low.
- CMD: shift 8'h03 MSB first. ADDR: shift BOOT_ADDR, 24 bits, MSB first.
- SPI timing:
  - flash_io0 changes while flash_clk is low.
  - flash_io1 is sampled on the rising edge of flash_clk.
  - Each bit is 2*SCK_HALF clocks.
  - flash_clk idles low.
  - flash_io0 = 0 during read phases.
- HDR: read 8 bits into N. MASK: read 8 bits into M.
  - mprj_io_oeb is not updated until the first pattern is applied.
- DATA: read byte Di, then in the same cycle:
  - mprj_io_out <= Di.
  - mprj_io_oeb <= ~M with bit 3 forced to 1.
- HOLD: flash_clk parked low and csb kept low; wait HOLD_CYCLES clocks.
  - If more patterns remain, return to DATA for the next byte (streaming read continues). Otherwise go to DONE.
- After the last pattern is applied: csb goes high, boot_done=1, the final pattern persists indefinitely.
- N=0:
  - Image read ends after MASK.
  - mprj_io_out <= 0, mprj_io_oeb <= ~M with bit 3 forced to 1.
  - csb high, boot_done=1.
- Pin 3: mprj_io_oeb[3]=1 and mprj_io_out[3]=0 in every state.
- mprj_io_in is not used by the sequencer. It is provided for pin-level observation only; pin 3 reads the external CSB level.
- Flash returning X/Z: the data is treated as sampled, with no retry.
- Byte/bit ordering: MSB first for all fields.

Test Plan:
- Image 01 F7 4F; external driver holds io[3]=1 -> pad byte io[7:0] == 8'h4F. Expect mprj_io_oeb=8'h08, mprj_io_out=8'h47, boot_done=1.
- SPI protocol check with BOOT_ADDR=24'h000010 and SCK_HALF=2 -> first 32 bits on io0 are 03 00 00 10. Expect flash_clk period of 4 clocks, csb low for the whole transaction, flash_clk low at each csb edge.
- Image 03 FF 01 02 03, HOLD_CYCLES=10 -> out sequence 01, 02, 03 (bit 3 masked), each held >=10 clocks. Expect oeb=8'h08 and boot_done set only after 03.
- Image 00 F0 -> out=8'h00, oeb=8'h0F, boot_done=1, no data-byte clocks after MASK.
- Assert resetb low during the ADDR phase -> csb=1 and oeb=8'hFF immediately. After release, a full fresh transaction completes with correct results.
- Timing check: with STARTUP_CYCLES=16, csb stays high for exactly 16 clocks after reset release.

Source files
------------

// File: rtl/caravel_io_boot.sv
// Boot sequencer: reads a pattern image from SPI NOR flash (READ 0x03) after reset
// and plays it out on the user I/O pins mprj_io[7:0]. Pin 3 is never driven.
module caravel_io_boot #(
    parameter logic [23:0] BOOT_ADDR      = 24'h000000,
    parameter int          STARTUP_CYCLES = 16,
    parameter int          SCK_HALF       = 1,
    parameter int          HOLD_CYCLES    = 1000
) (
    input  logic       clock,
    input  logic       resetb,
    output logic       flash_csb,
    output logic       flash_clk,
    output logic       flash_io0,
    input  logic       flash_io1,
    input  logic [7:0] mprj_io_in,
    output logic [7:0] mprj_io_out,
    output logic [7:0] mprj_io_oeb,
    output logic       boot_done
);

    typedef enum logic [2:0] {
        S_WAIT, S_CMD, S_ADDR, S_HDR, S_MASK, S_DATA, S_HOLD, S_DONE
    } state_t;

    localparam logic [7:0] PIN3 = 8'h08;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] half_q, half_d;
    logic        sck_q, sck_d;
    logic [4:0]  bitn_q, bitn_d;
    logic [23:0] sh_q, sh_d;
    logic [7:0]  n_q, n_d;
    logic [7:0]  m_q, m_d;
    logic [7:0]  left_q, left_d;
    logic        csb_q, csb_d;
    logic        io0_q, io0_d;
    logic [7:0]  out_q, out_d;
    logic [7:0]  oeb_q, oeb_d;
    logic        done_q, done_d;

    logic shifting, tx_phase, rx_phase;
    logic half_end, byte_done, wait_end, hold_end;

    // Pad inputs are observation-only; the sequencer never looks at them.
    logic unused_io;
    assign unused_io = ^mprj_io_in;

    assign tx_phase  = (state_q == S_CMD) || (state_q == S_ADDR);
    assign rx_phase  = (state_q == S_HDR) || (state_q == S_MASK) || (state_q == S_DATA);
    assign shifting  = tx_phase || rx_phase;
    assign half_end  = (half_q == 16'(SCK_HALF - 1));
    // A bit ends on the falling flash_clk edge; the byte ends on its last bit.
    assign byte_done = shifting && half_end && sck_q && (bitn_q == 5'd0);
    assign wait_end  = (cnt_q == 32'(STARTUP_CYCLES - 1));
    assign hold_end  = (cnt_q == 32'(HOLD_CYCLES - 1));

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q <= S_WAIT;
            cnt_q   <= '0;
            half_q  <= '0;
            sck_q   <= 1'b0;
            bitn_q  <= '0;
            sh_q    <= '0;
            n_q     <= '0;
            m_q     <= '0;
            left_q  <= '0;
            csb_q   <= 1'b1;
            io0_q   <= 1'b0;
            out_q   <= 8'h00;
            oeb_q   <= 8'hFF;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            sck_q   <= sck_d;
            bitn_q  <= bitn_d;
            sh_q    <= sh_d;
            n_q     <= n_d;
            m_q     <= m_d;
            left_q  <= left_d;
            csb_q   <= csb_d;
            io0_q   <= io0_d;
            out_q   <= out_d;
            oeb_q   <= oeb_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT:  if (wait_end)  state_d = S_CMD;
            S_CMD:   if (byte_done) state_d = S_ADDR;
            S_ADDR:  if (byte_done) state_d = S_HDR;
            S_HDR:   if (byte_done) state_d = S_MASK;
            S_MASK:  if (byte_done) state_d = (n_q == 8'd0) ? S_DONE : S_DATA;
            S_DATA:  if (byte_done) state_d = (left_q == 8'd1) ? S_DONE : S_HOLD;
            S_HOLD:  if (hold_end)  state_d = S_DATA;
            default: state_d = S_DONE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        half_d = half_q;
        sck_d  = sck_q;
        bitn_d = bitn_q;
        sh_d   = sh_q;
        n_d    = n_q;
        m_d    = m_q;
        left_d = left_q;
        csb_d  = csb_q;
        io0_d  = io0_q;
        out_d  = out_q;
        oeb_d  = oeb_q;
        done_d = done_q;

        // Bit engine: low half then high half; MISO sampled as flash_clk rises,
        // MOSI advanced as flash_clk falls.
        if (shifting) begin
            if (half_end) begin
                half_d = '0;
                if (!sck_q) begin
                    sck_d = 1'b1;
                    if (rx_phase) sh_d = {sh_q[22:0], flash_io1};
                end else begin
                    sck_d  = 1'b0;
                    bitn_d = bitn_q - 5'd1;
                    if (tx_phase) begin
                        sh_d  = {sh_q[22:0], 1'b0};
                        io0_d = sh_q[22];
                    end
                end
            end else begin
                half_d = half_q + 16'd1;
            end
        end

        case (state_q)
            S_WAIT: begin
                cnt_d = cnt_q + 32'd1;
                if (wait_end) begin
                    cnt_d  = '0;
                    csb_d  = 1'b0;
                    sh_d   = {8'h03, 16'h0000};
                    io0_d  = 1'b0;
                    bitn_d = 5'd7;
                    half_d = '0;
                    sck_d  = 1'b0;
                end
            end
            S_CMD: if (byte_done) begin
                sh_d   = BOOT_ADDR;
                io0_d  = BOOT_ADDR[23];
                bitn_d = 5'd23;
            end
            S_ADDR: if (byte_done) begin
                io0_d  = 1'b0;
                bitn_d = 5'd7;
            end
            S_HDR: if (byte_done) begin
                n_d    = sh_q[7:0];
                bitn_d = 5'd7;
            end
            S_MASK: if (byte_done) begin
                m_d    = sh_q[7:0];
                left_d = n_q;
                bitn_d = 5'd7;
                if (n_q == 8'd0) begin
                    out_d  = 8'h00;
                    oeb_d  = ~sh_q[7:0] | PIN3;
                    csb_d  = 1'b1;
                    done_d = 1'b1;
                end
            end
            S_DATA: if (byte_done) begin
                out_d  = sh_q[7:0] & ~PIN3;
                oeb_d  = ~m_q | PIN3;
                left_d = left_q - 8'd1;
                bitn_d = 5'd7;
                cnt_d  = '0;
                if (left_q == 8'd1) begin
                    csb_d  = 1'b1;
                    done_d = 1'b1;
                end
            end
            S_HOLD: begin
                cnt_d = cnt_q + 32'd1;
                if (hold_end) begin
                    cnt_d  = '0;
                    half_d = '0;
                    sck_d  = 1'b0;
                    bitn_d = 5'd7;
                end
            end
            default: ;
        endcase
    end

    assign flash_csb   = csb_q;
    assign flash_clk   = sck_q;
    assign flash_io0   = io0_q;
    assign mprj_io_out = out_q;
    assign mprj_io_oeb = oeb_q;
    assign boot_done   = done_q;

endmodule

// File: tb/tb_caravel_io_boot.sv
// Bench for caravel_io_boot: behavioural SPI flash plus an image-level reference
// model of the pin patterns the sequencer should play out.
module tb_caravel_io_boot;

    localparam logic [23:0] BA = 24'h000010;
    localparam int SC = 16;
    localparam int SH = 2;
    localparam int HC = 10;

    logic       clock = 1'b0;
    logic       resetb = 1'b0;
    logic       flash_csb, flash_clk, flash_io0;
    logic       flash_io1 = 1'b0;
    logic [7:0] mprj_io_in, mprj_io_out, mprj_io_oeb;
    logic       boot_done;

    caravel_io_boot #(
        .BOOT_ADDR(BA), .STARTUP_CYCLES(SC), .SCK_HALF(SH), .HOLD_CYCLES(HC)
    ) dut (
        .clock(clock), .resetb(resetb),
        .flash_csb(flash_csb), .flash_clk(flash_clk),
        .flash_io0(flash_io0), .flash_io1(flash_io1),
        .mprj_io_in(mprj_io_in), .mprj_io_out(mprj_io_out),
        .mprj_io_oeb(mprj_io_oeb), .boot_done(boot_done)
    );

    // Pad ring: driven pins show the output, undriven pins see the board
    // (external CSB holds io[3] high, other inputs read 0).
    assign mprj_io_in = (mprj_io_out & ~mprj_io_oeb) | (8'h08 & mprj_io_oeb);

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Flash model state
    logic [7:0]  mem [0:511];
    logic [31:0] cmd_bits;
    int          rc;
    int          cyc = 0;
    int          rise_cyc[$];
    int          fb, fi;

    always @(posedge clock) cyc++;

    always @(negedge flash_csb) rc = 0;

    always @(posedge flash_clk) begin
        if (!flash_csb) begin
            if (rc < 32) cmd_bits = {cmd_bits[30:0], flash_io0};
            else check("io0_read_phase", 32'(flash_io0), 32'd0);
            rise_cyc.push_back(cyc);
            rc++;
        end
    end

    always @(negedge flash_clk) begin
        if (!flash_csb && rc >= 32) begin
            fb = rc - 32;
            fi = (int'(cmd_bits[8:0]) + fb / 8) % 512;
            flash_io1 = mem[fi][7 - (fb % 8)];
        end
    end

    // Scoreboard of patterns expected on mprj_io_out
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;
    int         n_exp;
    int         applied;
    logic       prev_csb;

    always @(negedge clock) begin
        if (resetb) begin
            check("pin3_oeb", 32'(mprj_io_oeb[3]), 32'd1);
            check("pin3_out", 32'(mprj_io_out[3]), 32'd0);
            if (flash_csb !== prev_csb) check("sck_at_csb_edge", 32'(flash_clk), 32'd0);
            prev_csb = flash_csb;
            if (rc > 48 && (rc - 48) % 8 == 0 && applied == (rc - 48) / 8 - 1 && !flash_clk) begin
                if (exp_q.size() == 0) begin
                    check("extra_pattern", 32'(applied + 1), 32'(n_exp));
                end else begin
                    exp_v = exp_q.pop_front();
                    check("pattern", 32'(mprj_io_out), 32'(exp_v));
                    check("done_at_apply", 32'(boot_done), 32'(applied + 1 == n_exp));
                end
                applied++;
            end
            if (!flash_csb && applied == 0) check("oeb_before_first", 32'(mprj_io_oeb), 32'hFF);
        end
    end

    logic [7:0] img[$];

    task automatic run_boot(input bit abort);
        int         n, k, rc_save;
        logic [7:0] m, e_out, e_oeb, e_pad;
        n = int'(img[0]);
        m = img[1];
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < img.size(); i++) mem[int'(BA[8:0]) + i] = img[i];
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(img[2 + i] & 8'hF7);
        n_exp   = n;
        e_out   = (n == 0) ? 8'h00 : (img[1 + n] & 8'hF7);
        e_oeb   = ~m | 8'h08;
        e_pad   = (e_out & ~e_oeb) | (8'h08 & e_oeb);

        resetb = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_csb", 32'(flash_csb), 32'd1);
        check("rst_clk", 32'(flash_clk), 32'd0);
        check("rst_io0", 32'(flash_io0), 32'd0);
        check("rst_out", 32'(mprj_io_out), 32'h00);
        check("rst_oeb", 32'(mprj_io_oeb), 32'hFF);
        check("rst_done", 32'(boot_done), 32'd0);
        applied  = 0;
        rc       = 0;
        prev_csb = 1'b1;
        cmd_bits = '0;
        rise_cyc.delete();
        resetb = 1'b1;

        k = 0;
        while (flash_csb && k < 100) begin
            @(posedge clock);
            #1;
            k++;
        end
        check("startup_cycles", 32'(k), 32'(SC));

        if (abort) begin
            k = 0;
            while (rc < 36 && k < 5000) begin
                @(posedge clock);
                k++;
            end
            check("reach_addr", 32'(rc >= 36), 32'd1);
            #3 resetb = 1'b0;
            #1;
            check("abort_csb", 32'(flash_csb), 32'd1);
            check("abort_oeb", 32'(mprj_io_oeb), 32'hFF);
            check("abort_clk", 32'(flash_clk), 32'd0);
            return;
        end

        k = 0;
        while (!boot_done && k < 20000) begin
            @(negedge clock);
            k++;
        end
        check("done_timeout", 32'(boot_done), 32'd1);
        repeat (5) @(negedge clock);
        check("final_out", 32'(mprj_io_out), 32'(e_out));
        check("final_oeb", 32'(mprj_io_oeb), 32'(e_oeb));
        check("final_pad", 32'(mprj_io_in), 32'(e_pad));
        check("final_csb", 32'(flash_csb), 32'd1);
        check("cmd_addr_bits", cmd_bits, {8'h03, BA});
        check("total_rises", 32'(rc), 32'(48 + 8 * n));
        check("patterns_applied", 32'(applied), 32'(n));
        check("sck_period", 32'(rise_cyc[1] - rise_cyc[0]), 32'(2 * SH));
        if (rise_cyc.size() >= 48 + 8 * n) begin
            for (int i = 1; i < n; i++)
                check("hold_gap", 32'(rise_cyc[48 + 8 * i] - rise_cyc[47 + 8 * i] >= HC), 32'd1);
        end
        rc_save = rc;
        repeat (50) @(negedge clock);
        check("persist_out", 32'(mprj_io_out), 32'(e_out));
        check("persist_done", 32'(boot_done), 32'd1);
        check("no_more_rises", 32'(rc), 32'(rc_save));
    endtask

    initial begin
        int n;
        img = '{8'h01, 8'hF7, 8'h4F};
        run_boot(1'b0);
        img = '{8'h03, 8'hFF, 8'h01, 8'h02, 8'h03};
        run_boot(1'b0);
        img = '{8'h00, 8'hF0};
        run_boot(1'b0);
        img = '{8'h02, 8'h3C, 8'hA5, 8'h5A};
        run_boot(1'b1);
        run_boot(1'b0);
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(0, 5);
            img.delete();
            img.push_back(8'(n));
            img.push_back(8'($urandom));
            for (int i = 0; i < n; i++) img.push_back(8'($urandom));
            run_boot(1'b0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
